// File: rtl/seg_pkg.sv
// Seven-segment glyph constants ({g,f,e,d,c,b,a}, active-high) and BCD decode.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Non-decimal codes 10..15 render as a dash.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to active-high segment pattern {g..a}.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  always_comb o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-slot dead time.
// Optional digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 32,
  parameter int unsigned DEAD_CYC  = 2,
  parameter int unsigned BLINK_DIV = 16
) (
  input  logic                  clk_src,
  input  logic                  reset,
  input  logic                  power,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            cnodes,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] r_anodes;
  logic [7:0]        r_cnodes;
  logic              r_frame_tick;

  logic              w_slot_end;
  logic              w_frame_wrap;
  logic              w_dead;
  logic              w_blink_blank;
  logic              w_show;
  logic [3:0]        w_bcd;
  seg_t              w_seg;
  logic [DIGITS-1:0] w_sel;

  assign w_slot_end   = (r_scan_cnt == CNT_LAST);
  assign w_frame_wrap = w_slot_end && (r_idx == IDX_LAST);
  assign w_dead       = 32'(r_scan_cnt) < DEAD_CYC;

  always_comb begin
    w_bcd        = digits[4*r_idx +: 4];
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

  seg_decoder u_dec (
    .i_bcd (w_bcd),
    .o_seg (w_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_ph;

  // Advances on the same edge that raises frame_tick, so each blink phase covers whole frames.
  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (!power) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_blank = blink_mask[r_idx] & r_blink_ph;
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_blank  = 1'b0;
`endif

  assign w_show = !w_dead && digit_en[r_idx] && !w_blink_blank;

  always_ff @(posedge clk_src or negedge reset) begin
    if (!reset) begin
      r_scan_cnt   <= '0;
      r_idx        <= '0;
      r_anodes     <= '1;
      r_cnodes     <= '1;
      r_frame_tick <= 1'b0;
    end else if (!power) begin
      r_scan_cnt   <= '0;
      r_idx        <= '0;
      r_anodes     <= '1;
      r_cnodes     <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_scan_cnt   <= w_slot_end ? '0 : r_scan_cnt + 1'b1;
      if (w_slot_end)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      r_frame_tick <= w_frame_wrap;
      if (w_show) begin
        r_anodes <= ~w_sel;
        r_cnodes <= ~{dp_mask[r_idx], w_seg};
      end else begin
        r_anodes <= '1;
        r_cnodes <= ~{1'b0, SEG_BLANK};
      end
    end
  end

  assign anodes     = r_anodes;
  assign cnodes     = r_cnodes;
  assign frame_tick = r_frame_tick;

endmodule
